// File: rtl/pim_job_sequencer.sv
// pim_job_sequencer: streams weight rows and one activation vector from SRAM
// into the PIM write port, waits for the result and captures it.
module pim_job_sequencer #(
    parameter int MEM_AW    = 12,
    parameter int ACT_BEATS = 9,
    parameter int TIMEOUT   = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [MEM_AW-1:0] i_w_base,
    input  logic [8:0]        i_w_rows,
    input  logic [MEM_AW-1:0] i_a_base,
    output logic              o_mem_req,
    output logic [MEM_AW-1:0] o_mem_addr,
    input  logic [31:0]       i_mem_rdata,
    output logic [31:0]       o_pim_addr,
    output logic [31:0]       o_pim_wdata,
    input  logic              i_pim_valid,
    input  logic [31:0]       i_pim_rdata,
    output logic [31:0]       o_res_data,
    output logic              o_res_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_LOAD   = 3'd1,
        GAP      = 3'd2,
        A_LOAD   = 3'd3,
        WAIT_RES = 3'd4,
        RD       = 3'd5,
        CAP      = 3'd6
    } state_t;

    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [12:0]     ACT_N   = 13'(ACT_BEATS);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [12:0]       beat;
    logic [12:0]       total;
    logic              gap;
    logic [TW-1:0]     wcnt;
    logic [MEM_AW-1:0] w_base;
    logic [MEM_AW-1:0] a_base;
    logic              rows_ok;
    logic              accept;
    logic              timeout;
    logic              capture;
    logic              rd_en;
    logic [31:0]       pim_nxt;

    assign rows_ok = (i_w_rows != 9'd0) && (i_w_rows <= 9'd288);
    assign accept  = (state == IDLE) && i_start && rows_ok;
    assign timeout = (state == WAIT_RES) && !i_pim_valid && (wcnt == TO_LAST);
    assign capture = (state == RD) && !i_abort;
    assign o_busy  = (state != IDLE);
    assign o_state = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (accept) state_nxt = W_LOAD;
            W_LOAD:   if (beat == total) state_nxt = GAP;
            GAP:      if (gap) state_nxt = A_LOAD;
            A_LOAD:   if (beat == ACT_N) state_nxt = WAIT_RES;
            WAIT_RES: begin
                if (i_pim_valid)  state_nxt = RD;
                else if (timeout) state_nxt = IDLE;
            end
            RD:       state_nxt = CAP;
            CAP:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (i_abort && state != IDLE) state_nxt = IDLE;
    end

    // Reads lead the PIM write by one cycle; the write address is registered.
    always_comb begin
        rd_en = 1'b0;
        unique case (state)
            W_LOAD:  rd_en = (beat < total);
            GAP:     rd_en = gap;
            A_LOAD:  rd_en = (beat < ACT_N);
            default: rd_en = 1'b0;
        endcase
        if (i_abort) rd_en = 1'b0;
        o_mem_req  = rd_en;
        o_mem_addr = '0;
        pim_nxt    = 32'h0;
        if (rd_en) begin
            o_mem_addr = ((state == W_LOAD) ? w_base : a_base) + MEM_AW'(beat);
            pim_nxt    = ((state == W_LOAD) ? 32'h4000_0040 : 32'h4000_0080)
                       | (32'h1 << beat[1:0]);
        end else if (state == WAIT_RES && i_pim_valid && !i_abort) begin
            pim_nxt = 32'h4000_0020;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat        <= '0;
            total       <= '0;
            gap         <= 1'b0;
            wcnt        <= '0;
            w_base      <= '0;
            a_base      <= '0;
            o_pim_addr  <= '0;
            o_pim_wdata <= '0;
            o_res_data  <= '0;
            o_res_valid <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            if (accept) begin
                w_base <= i_w_base;
                a_base <= i_a_base;
                total  <= {i_w_rows, 4'h0};
            end
            if (state_nxt != state && (state_nxt == W_LOAD || state_nxt == GAP))
                beat <= '0;
            else if (rd_en)
                beat <= beat + 13'd1;
            gap         <= (state == GAP) && (state_nxt == GAP);
            wcnt        <= (state == WAIT_RES) ? wcnt + TW'(1) : '0;
            o_pim_addr  <= pim_nxt;
            o_pim_wdata <= rd_en ? i_mem_rdata : 32'h0;
            o_res_valid <= capture;
            o_done      <= capture;
            if (capture) o_res_data <= i_pim_rdata;
            if (i_start)
                o_err <= (state != IDLE) || !rows_ok;
            else if (timeout && !i_abort)
                o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pim_job_sequencer.sv
// tb_pim_job_sequencer: scoreboard bench for pim_job_sequencer with
// behavioural SRAM and an XOR-accumulating PIM result model.
module tb_pim_job_sequencer;

    localparam logic [31:0] RD_ADDR = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_pim_valid = 1'b0;
    logic [11:0] i_w_base = '0;
    logic [11:0] i_a_base = '0;
    logic [8:0]  i_w_rows = '0;
    logic        o_mem_req;
    logic [11:0] o_mem_addr;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_pim_addr;
    logic [31:0] o_pim_wdata;
    logic [31:0] i_pim_rdata;
    logic [31:0] o_res_data;
    logic        o_res_valid;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [2:0]  o_state;

    logic [31:0] mem [4096];
    logic [79:0] exp_q [$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ts = 0;
    int          ndone = 0;
    int          nreq = 0;
    int          exp_done_off = 0;
    logic [31:0] acc = '0;
    logic [31:0] exp_res = '0;
    bit          mon_en = 1'b0;

    pim_job_sequencer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_w_base    (i_w_base),
        .i_w_rows    (i_w_rows),
        .i_a_base    (i_a_base),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .o_pim_addr  (o_pim_addr),
        .o_pim_wdata (o_pim_wdata),
        .i_pim_valid (i_pim_valid),
        .i_pim_rdata (i_pim_rdata),
        .o_res_data  (o_res_data),
        .o_res_valid (o_res_valid),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_state     (o_state)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign i_mem_rdata = o_mem_req ? mem[o_mem_addr] : 32'h0;
    assign i_pim_rdata = (o_pim_addr == RD_ADDR) ? acc : 32'h0;

    task automatic check(input string tag, input logic [79:0] got,
                         input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every nonzero PIM address is one scoreboard entry: {offset, addr, data}.
    initial forever begin
        @(negedge clk);
        if (rst_n && mon_en) begin
            if (o_mem_req) nreq++;
            if (o_pim_addr != 32'h0) begin
                if (o_pim_addr != RD_ADDR) acc ^= o_pim_wdata;
                if (exp_q.size() == 0)
                    check("extra_wr", {16'(cyc - ts), o_pim_addr, o_pim_wdata}, 80'h0);
                else
                    check("wr", {16'(cyc - ts), o_pim_addr, o_pim_wdata},
                          exp_q.pop_front());
            end
            if (o_done) begin
                ndone++;
                check("done_t", 80'(cyc - ts), 80'(exp_done_off));
                check("res", 80'(o_res_data), 80'(exp_res));
                check("res_v", 80'(o_res_valid), 80'h1);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 80'({o_mem_req, o_mem_addr, o_res_valid, o_busy,
                                  o_done, o_err, o_state}), 80'h0);
        check({tag, "_pim"}, 80'({o_pim_addr, o_pim_wdata}), 80'h0);
        check({tag, "_res"}, 80'(o_res_data), 80'h0);
    endtask

    // ev_kind: 0 none, 1 start pulse at ev_off, 2 abort at ev_off. vdel<0: no valid.
    task automatic run_job(input logic [11:0] wb, input logic [8:0] rows,
                           input logic [11:0] ab, input int vdel,
                           input int ev_kind, input int ev_off, input int n_act);
        int          tot;
        int          off;
        int          vld_off;
        int          end_exp;
        int          busy_low;
        bit          got_idle;
        bit          done_exp;
        bit          err_exp;
        logic [31:0] d;
        tot      = 16 * int'(rows);
        vld_off  = tot + 12 + vdel;
        done_exp = (vdel >= 0) && (ev_kind != 2);
        err_exp  = (ev_kind == 1) || (vdel < 0);
        if (ev_kind == 2)  end_exp = ev_off + 1;
        else if (vdel < 0) end_exp = tot + 1036;
        else               end_exp = vld_off + 3;
        @(negedge clk);
        i_w_base = wb;
        i_w_rows = rows;
        i_a_base = ab;
        i_start  = 1'b1;
        ts       = cyc;
        acc      = '0;
        exp_res  = '0;
        ndone    = 0;
        busy_low = 0;
        exp_done_off = vld_off + 2;
        for (int k = 0; k < tot; k++) begin
            d = mem[12'(int'(wb) + k)];
            exp_res ^= d;
            exp_q.push_back({16'(k + 2), 32'h4000_0040 | (32'h1 << (k % 4)), d});
        end
        for (int k = 0; k < n_act; k++) begin
            d = mem[12'(int'(ab) + k)];
            exp_res ^= d;
            exp_q.push_back({16'(tot + 4 + k), 32'h4000_0080 | (32'h1 << (k % 4)), d});
        end
        if (done_exp) exp_q.push_back({16'(vld_off + 1), RD_ADDR, 32'h0});
        got_idle = 1'b0;
        off      = 0;
        for (int i = 0; i < 6000 && !got_idle; i++) begin
            @(negedge clk);
            off = cyc - ts;
            if (o_state == 3'd0) begin
                got_idle = 1'b1;
            end else begin
                if (!o_busy) busy_low++;
                i_start     = (ev_kind == 1) && (off == ev_off);
                i_abort     = (ev_kind == 2) && (off == ev_off);
                i_pim_valid = (vdel >= 0) && (off == vld_off);
            end
        end
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_pim_valid = 1'b0;
        check("idle_reached", 80'(got_idle), 80'h1);
        check("end_t", 80'(off), 80'(end_exp));
        check("pim_idle", 80'(o_pim_addr), 80'h0);
        check("ndone", 80'(ndone), 80'(done_exp));
        check("err", 80'(o_err), 80'(err_exp));
        check("busy", 80'(busy_low), 80'h0);
        check("sb_left", 80'(exp_q.size()), 80'h0);
        exp_q.delete();
    endtask

    task automatic bad_start(input logic [8:0] rows);
        int busy_seen;
        @(negedge clk);
        i_w_rows  = rows;
        i_start   = 1'b1;
        nreq      = 0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_busy) busy_seen++;
        end
        check("bad_err", 80'(o_err), 80'h1);
        check("bad_busy", 80'(busy_seen), 80'h0);
        check("bad_req", 80'(nreq), 80'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        i_w_base = 12'h123;
        i_w_rows = 9'd2;
        i_a_base = 12'h456;
        i_start  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_w_state", 80'(o_state), 80'h1);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_mid");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_job(12'h010, 9'd1, 12'h100, 20, 0, 0, 9);
        run_job(12'h200, 9'd2, 12'h300, 5, 1, 38, 9);
        run_job(12'h010, 9'd1, 12'h100, 20, 2, 24, 5);
        bad_start(9'd0);
        run_job(12'hFF0, 9'd288, 12'hFFC, 20, 0, 0, 9);
        bad_start(9'd289);
        run_job(12'h040, 9'd1, 12'h140, -1, 0, 0, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pim_job_sequencer.md
# pim_job_sequencer

Autonomous sequencer that runs one complete PIM job: it streams weight rows and one activation vector from local SRAM into the PIM controller's memory-mapped write port, waits for the result, then reads it back. It sits between the CPU register file, which supplies the job descriptor and start pulse, and the PIM controller/wrapper bus. It produces the address/data stream with the exact contiguity the PIM controller's beat counters require, which frees the CPU from cycle-exact issue.

## Interface
- MEM_AW, 12, SRAM word-address width
- ACT_BEATS, 9, activation beats per job (PIM activation counter wraps at 8)
- TIMEOUT, 1023, max cycles waiting for result valid

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle job start pulse
- i_abort  in  1  synchronous abort
- i_w_base  in  MEM_AW  SRAM word address of first weight word
- i_w_rows  in  9  weight rows to load, 1..288
- i_a_base  in  MEM_AW  SRAM word address of first activation word
- o_mem_req  out  1  SRAM read enable
- o_mem_addr  out  MEM_AW  SRAM read address
- i_mem_rdata  in  32  SRAM data, fixed 1-cycle latency after o_mem_req
- o_pim_addr  out  32  PIM bus address, 0 when idle
- o_pim_wdata  out  32  PIM bus write data
- i_pim_valid  in  1  PIM result valid
- i_pim_rdata  in  32  PIM result data
- o_res_data  out  32  captured result
- o_res_valid  out  1  one-cycle result strobe
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle job-complete pulse
- o_err  out  1  sticky error: timeout, or start while busy; cleared by the next accepted start
- o_state  out  3  FSM state encoding, for debug

## Operation
- States: IDLE(0), W_LOAD(1), GAP(2), A_LOAD(3), WAIT_RES(4), RD(5), CAP(6).
- IDLE: i_start latches the descriptor and moves to W_LOAD. If i_w_rows is 0 or greater than 288, the sequencer sets o_err and stays in IDLE.
- W_LOAD: the sequencer issues i_w_rows*16 SRAM reads back-to-back from i_w_base.
  - Each returned word becomes one PIM write with no gap cycles.
  - Beat k drives o_pim_addr = 0x4000_0040 | (1 << (k mod 4)), i.e. 0x41, 0x42, 0x44, 0x48, repeating.
  - The last read issues, then the last write follows one cycle later, then the state moves to GAP.
- GAP: exactly 2 cycles with o_pim_addr = 0, so the PIM weight-busy flag and beat counter clear. The second GAP cycle issues the first activation read.
- A_LOAD: ACT_BEATS contiguous writes from i_a_base. Beat k drives o_pim_addr = 0x4000_0080 | (1 << (k mod 4)). The state then moves to WAIT_RES with o_pim_addr = 0.
- WAIT_RES: the sequencer holds address 0 and counts cycles.
  - i_pim_valid moves the state to RD.
  - If the count reaches TIMEOUT, o_err is set and the state returns to IDLE without o_done.
- RD: one cycle with o_pim_addr = 0x4000_0020.
- CAP: o_res_data <= i_pim_rdata, with o_res_valid and o_done pulsed in the same cycle, then the state returns to IDLE.
- SRAM addresses increment modulo 2^MEM_AW and wrap silently.
- A beat counter (13 bits) and a row-independent lane index (beat[1:0]) generate addresses. Write data is i_mem_rdata registered into o_pim_wdata, aligned with o_pim_addr.
- i_abort in any non-IDLE state: next state is IDLE, o_pim_addr = 0, o_mem_req = 0, no o_done, o_err unchanged. Abort takes priority over all other transitions.
- i_start while busy is ignored and sets o_err.

## Timing
- Reset (async assert, sync deassert): state IDLE, and o_mem_req, o_mem_addr, o_pim_addr, o_pim_wdata, o_res_data, o_res_valid, o_busy, o_done, o_err and o_state all 0.
- Start at cycle T: W_LOAD at T+1, first o_mem_req at T+1, first PIM write at T+2.
- Weight writes occupy cycles T+2 .. T+1+16R, where R = i_w_rows.
- GAP occupies the next 2 cycles. Activation writes occupy the 9 cycles after that.
- RD comes 1 cycle after i_pim_valid is sampled high. CAP/o_done comes 1 cycle after RD.
- o_busy is high from T+1 through the CAP cycle inclusive.
- Write stream rule: the PIM address is never 0 inside a phase and never anything other than 0 between phases.

## Test plan
- Reset mid-W_LOAD -> all outputs 0 immediately; the next start runs a clean job from beat 0.
- Job R=1, w_base=0x010, a_base=0x100, valid 20 cycles after the last activation write:
  - 16 weight writes with addresses 0x41, 0x42, 0x44, 0x48 ×4, data = SRAM[0x010..0x01F].
  - 2-cycle gap.
  - 9 activation writes 0x81..0x81 pattern with data = SRAM[0x100..0x108].
  - RD at 0x4000_0020, then o_res_data = model result and o_done pulse.
- R=288, w_base=0xFF0 -> 4608 contiguous writes; SRAM address wraps 0xFFF to 0x000; o_err stays 0.
- i_pim_valid never asserted -> after 1023 WAIT_RES cycles o_err=1, state IDLE, no o_done.
- i_start during A_LOAD -> ignored and o_err=1; the running job completes normally. i_abort on the 5th activation beat -> IDLE next cycle and o_pim_addr=0.
- Start with R=0 and with R=289 -> o_err=1, no SRAM reads, o_busy stays 0.
